// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage core: register addressing and
// the hazard controller state encoding.
package cpu_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } hz_state_e;

endpackage : cpu_pkg

// File: rtl/hazard_cmp.sv
// Combinational load-use comparator: flags when a load in EX writes a register
// the instruction in ID reads. Register 0 is hardwired and never hazards.
module hazard_cmp
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] op1_i,
  input  logic [REG_W-1:0] op2_i,
  input  logic             use1_i,
  input  logic             use2_i,
  input  logic [REG_W-1:0] dest_i,
  input  logic             rd_i,
  output logic             hit_o
);

  logic match1;
  logic match2;

  assign match1 = use1_i && (op1_i == dest_i);
  assign match2 = use2_i && (op2_i == dest_i);
  assign hit_o  = rd_i && (dest_i != REG_ZERO) && (match1 || match2);

endmodule : hazard_cmp

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles and taken-branch squash.
// Optional perf counters load_stalls/br_flushes are enabled by HAZARD_PERF_EN.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_op1,
  input  logic [REG_W-1:0] id_op2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_r,
  input  logic             br_taken,
  output logic             stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]      load_stalls,
  output logic [15:0]      br_flushes
`endif
);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > (1 << CNT_W)) begin : g_bad_param
    $error("hazard_ctrl: LOAD_BUBBLES=%0d out of range for CNT_W=%0d", LOAD_BUBBLES, CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit;
  logic             load_stall;

  hazard_cmp u_cmp (
    .op1_i  (id_op1),
    .op2_i  (id_op2),
    .use1_i (id_use1),
    .use2_i (id_use2),
    .dest_i (ex_dest),
    .rd_i   (ex_r),
    .hit_o  (hit)
  );

  // A taken branch overrides both a fresh hit and any remaining bubbles.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    stall      = 1'b0;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    load_stall = 1'b0;
    busy       = (state_q != IDLE);
    if (br_taken) begin
      stall      = 1'b1;
      ifid_flush = 1'b1;
      state_d    = IDLE;
      count_d    = '0;
    end else if (state_q == LSTALL) begin
      stall      = 1'b1;
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      load_stall = 1'b1;
      if (count_q <= CNT_ONE) begin
        state_d = IDLE;
        count_d = '0;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end else if (hit) begin
      stall      = 1'b1;
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      load_stall = 1'b1;
      if (LOAD_BUBBLES > 1) begin
        state_d = LSTALL;
        count_d = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] load_stalls_q, br_flushes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_stalls_q <= '0;
      br_flushes_q  <= '0;
    end else begin
      if (load_stall && load_stalls_q != 16'hFFFF) load_stalls_q <= load_stalls_q + 16'd1;
      if (ifid_flush && br_flushes_q != 16'hFFFF)  br_flushes_q  <= br_flushes_q + 16'd1;
    end
  end

  assign load_stalls = load_stalls_q;
  assign br_flushes  = br_flushes_q;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 bubbles) on shared inputs,
// checked every cycle against a remaining-bubble reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] id_op1 = '0, id_op2 = '0, ex_dest = '0;
  logic       id_use1 = 1'b0, id_use2 = 1'b0, ex_r = 1'b0, br_taken = 1'b0;

  logic a_stall, a_pch, a_ifh, a_ifl, a_busy;
  logic b_stall, b_pch, b_ifh, b_ifl, b_busy;
`ifdef HAZARD_PERF_EN
  logic [15:0] a_ls, a_bf, b_ls, b_bf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(3)) u_b1 (
    .clk(clk), .reset(reset), .id_op1(id_op1), .id_op2(id_op2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_dest(ex_dest), .ex_r(ex_r),
    .br_taken(br_taken), .stall(a_stall), .pc_hold(a_pch), .ifid_hold(a_ifh),
    .ifid_flush(a_ifl), .busy(a_busy)
`ifdef HAZARD_PERF_EN
    , .load_stalls(a_ls), .br_flushes(a_bf)
`endif
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(3)) u_b3 (
    .clk(clk), .reset(reset), .id_op1(id_op1), .id_op2(id_op2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_dest(ex_dest), .ex_r(ex_r),
    .br_taken(br_taken), .stall(b_stall), .pc_hold(b_pch), .ifid_hold(b_ifh),
    .ifid_flush(b_ifl), .busy(b_busy)
`ifdef HAZARD_PERF_EN
    , .load_stalls(b_ls), .br_flushes(b_bf)
`endif
  );

  // Reference model: bubbles still owed after the current cycle, per instance.
  int lb [2] = '{1, 3};
  int rem [2] = '{0, 0};
  int perf_ls [2] = '{0, 0};
  int perf_bf [2] = '{0, 0};
  int stall_cnt [2] = '{0, 0};
  int busy_cnt [2] = '{0, 0};

  function automatic bit model_hit();
    return ex_r && (ex_dest != 4'd0) &&
           ((id_use1 && id_op1 == ex_dest) || (id_use2 && id_op2 == ex_dest));
  endfunction

  // Expected {stall, pc_hold, ifid_hold, ifid_flush, busy}
  function automatic logic [4:0] model_out(int r);
    if (br_taken)      return {4'b1001, r > 0};
    else if (r > 0)    return 5'b11101;
    else if (model_hit()) return 5'b11100;
    else               return 5'b00000;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [4:0] obs [2];
    @(negedge clk);
    obs[0] = {a_stall, a_pch, a_ifh, a_ifl, a_busy};
    obs[1] = {b_stall, b_pch, b_ifh, b_ifl, b_busy};
    if (reset) begin
      rem = '{0, 0};
      perf_ls = '{0, 0};
      perf_bf = '{0, 0};
    end
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "outs_lb1" : "outs_lb3", 16'(obs[k]), 16'(model_out(rem[k])));
      chk(k == 0 ? "excl_lb1" : "excl_lb3", 16'(obs[k][1] & (obs[k][2] | obs[k][3])), 16'd0);
      if (obs[k][4]) stall_cnt[k]++;
      if (obs[k][0]) busy_cnt[k]++;
    end
`ifdef HAZARD_PERF_EN
    chk("ls_lb1", a_ls, 16'(perf_ls[0]));
    chk("bf_lb1", a_bf, 16'(perf_bf[0]));
    chk("ls_lb3", b_ls, 16'(perf_ls[1]));
    chk("bf_lb3", b_bf, 16'(perf_bf[1]));
`endif
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        rem[k] = 0;
      end else if (br_taken) begin
        perf_bf[k]++;
        rem[k] = 0;
      end else if (rem[k] > 0) begin
        perf_ls[k]++;
        rem[k]--;
      end else if (model_hit()) begin
        perf_ls[k]++;
        rem[k] = lb[k] - 1;
      end
    end
    #1;
  endtask

  task automatic quiet();
    id_op1 = '0; id_op2 = '0; ex_dest = '0;
    id_use1 = 0; id_use2 = 0; ex_r = 0; br_taken = 0;
  endtask

  task automatic load_hit(input logic [3:0] d, input bit on_op2);
    quiet();
    ex_r = 1; ex_dest = d;
    if (on_op2) begin id_use2 = 1; id_op2 = d; end
    else begin id_use1 = 1; id_op1 = d; end
  endtask

  task automatic clr_cnt();
    stall_cnt = '{0, 0};
    busy_cnt = '{0, 0};
  endtask

  initial begin
    // Reset with quiet inputs
    quiet();
    cycle();
    cycle();
    #2 reset = 0;
    cycle();

    // Load-use on op2
    clr_cnt();
    load_hit(4'd3, 1'b1);
    cycle();
    quiet();
    repeat (4) cycle();
    chk("op2_stalls_lb1", 16'(stall_cnt[0]), 16'd1);
    chk("op2_busy_lb1", 16'(busy_cnt[0]), 16'd0);

    // Multi-bubble on dest 7
    clr_cnt();
    load_hit(4'd7, 1'b0);
    cycle();
    quiet();
    repeat (4) cycle();
    chk("multi_stalls_lb3", 16'(stall_cnt[1]), 16'd3);
    chk("multi_busy_lb3", 16'(busy_cnt[1]), 16'd2);

    // Register 0 and unused source
    clr_cnt();
    load_hit(4'd0, 1'b0);
    cycle();
    quiet();
    ex_r = 1; ex_dest = 4'd4; id_op1 = 4'd4; id_use1 = 0;
    cycle();
    chk("reg0_unused_stalls", 16'(stall_cnt[0] + stall_cnt[1]), 16'd0);

    // Branch in the 2nd stall cycle
    quiet();
    load_hit(4'd6, 1'b0);
    cycle();
    quiet();
    br_taken = 1;
    cycle();
    br_taken = 0;
    clr_cnt();
    repeat (2) cycle();
    chk("br_stall_after_lb3", 16'(stall_cnt[1]), 16'd0);

    // Branch and hit together in IDLE
    load_hit(4'd2, 1'b1);
    br_taken = 1;
    cycle();
    quiet();
    cycle();

    // Reset asserted mid-stall
    load_hit(4'd5, 1'b0);
    cycle();
    quiet();
    reset = 1;
    #1;
    chk("rst_mid_busy", 16'(b_busy), 16'd0);
    chk("rst_mid_stall", 16'(b_stall), 16'd0);
    cycle();
    #2 reset = 0;
    repeat (2) cycle();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      id_op1   = 4'($urandom_range(0, 7));
      id_op2   = 4'($urandom_range(0, 7));
      ex_dest  = 4'($urandom_range(0, 7));
      id_use1  = 1'($urandom_range(0, 1));
      id_use2  = 1'($urandom_range(0, 1));
      ex_r     = ($urandom_range(0, 2) != 0);
      br_taken = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 0;
    quiet();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
